// File: rtl/multi_clk_adder_lanes_pkg.sv
// Shared types and helpers for the multi-cycle lane adder.
// Holds the FSM state enum, beat-count and saturation helpers.
package multi_clk_adder_lanes_pkg;

  typedef enum logic [1:0] {
    MCA_IDLE   = 2'd0,
    MCA_ADDING = 2'd1,
    MCA_DONE   = 2'd2
  } state_mcal_e;

  // Widest accumulator the saturate helper can handle.
  localparam int MCA_MAX_W = 128;

  typedef struct packed {
    logic                 sat;
    logic [MCA_MAX_W-1:0] val;
  } mca_sat_t;

  function automatic int mca_num_beats(
    input int n,
    input int l
  );
    return (n + l - 1) / l;
  endfunction

  // v must already be sign-extended to MCA_MAX_W.
  function automatic mca_sat_t mca_saturate(
    input logic signed [MCA_MAX_W-1:0] v,
    input int                          acc_w,
    input int                          w_out
  );
    logic signed [MCA_MAX_W-1:0] hi;
    logic signed [MCA_MAX_W-1:0] lo;
    mca_sat_t r;
    hi = (MCA_MAX_W'(1) << (w_out - 1)) - MCA_MAX_W'(1);
    lo = ~hi;
    r.val = v;
    r.sat = 1'b0;
    if (w_out < acc_w) begin
      if (v > hi) begin
        r.val = hi;
        r.sat = 1'b1;
      end else if (v < lo) begin
        r.val = lo;
        r.sat = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_clk_adder_lanes_lane_sum.sv
// Combinational adder tree: sums LANES signed operands into ACC_W bits.
// Ports: vals (lane operands), mask (lane enables), sum (signed result).
module mca_lane_sum #(
  parameter int WIDTH_IN = 32,
  parameter int LANES    = 1,
  parameter int ACC_W    = 37
) (
  input  logic [LANES-1:0][WIDTH_IN-1:0] vals,
  input  logic [LANES-1:0]               mask,
  output logic signed [ACC_W-1:0]        sum
);

  always_comb begin
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] ext;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      ext = {{(ACC_W-WIDTH_IN){vals[i][WIDTH_IN-1]}},
             vals[i]};
      if (mask[i]) begin
        s = s + ext;
      end
    end
    sum = s;
  end

endmodule

// File: rtl/multi_clk_adder_lanes.sv
// Multi-cycle signed summation of NUM_OPERANDS values, LANES per beat.
// Ports: clk, resetn, enable, in_valid/in_ready/operands (job in),
//   out_valid/out_ready/res (result out), busy; sat_flag only when
//   MCA_SATURATE_EN is defined (clamp instead of wrap).
module multi_clk_adder_lanes
  import multi_clk_adder_lanes_pkg::*;
#(
  parameter int WIDTH_IN     = 32,
  parameter int WIDTH_OUT    = 32,
  parameter int NUM_OPERANDS = 16,
  parameter int LANES        = 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_OPERANDS-1:0][WIDTH_IN-1:0] operands,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [WIDTH_OUT-1:0]          res,
  output logic                                 busy
`ifdef MCA_SATURATE_EN
  ,
  output logic                                 sat_flag
`endif
);

  localparam int NUM_BEATS = mca_num_beats(NUM_OPERANDS, LANES);
  localparam int ACC_W     = WIDTH_IN + $clog2(NUM_OPERANDS) + 1;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PAD_N     = NUM_BEATS * LANES;
  localparam logic [BW-1:0] LAST = BW'(NUM_BEATS - 1);

  state_mcal_e state_q, state_d;

  logic [NUM_OPERANDS-1:0][WIDTH_IN-1:0] snap_q;
  logic signed [ACC_W-1:0]               acc_q;
  logic signed [ACC_W-1:0]               lane_sum;
  logic signed [ACC_W-1:0]               sum_fin;
  logic [BW-1:0]                         beat_q;
  logic                                  accept;
  logic                                  last_beat;
  logic [PAD_N*WIDTH_IN-1:0]             flat;
  logic [LANES-1:0][WIDTH_IN-1:0]        lane_vals;
  logic [LANES-1:0]                      lane_mask;
  logic signed [WIDTH_OUT-1:0]           res_next;
`ifdef MCA_SATURATE_EN
  logic                                  sat_next;
`endif

  assign in_ready  = (state_q == MCA_IDLE);
  assign busy      = (state_q != MCA_IDLE);
  assign out_valid = (state_q == MCA_DONE);
  assign accept    = enable & in_valid & in_ready;
  assign last_beat = (beat_q == LAST);

  // Zero-pad so the last beat can slice past NUM_OPERANDS safely.
  assign flat = (PAD_N*WIDTH_IN)'(snap_q);

  always_comb begin
    int base;
    base = int'(beat_q) * LANES;
    lane_vals = flat[base*WIDTH_IN +: LANES*WIDTH_IN];
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = ((base + i) < NUM_OPERANDS);
    end
  end

  mca_lane_sum #(
    .WIDTH_IN (WIDTH_IN),
    .LANES    (LANES),
    .ACC_W    (ACC_W)
  ) u_lane_sum (
    .vals (lane_vals),
    .mask (lane_mask),
    .sum  (lane_sum)
  );

  assign sum_fin = acc_q + lane_sum;

`ifdef MCA_SATURATE_EN
  always_comb begin
    mca_sat_t s;
    s = mca_saturate(
      {{(MCA_MAX_W-ACC_W){sum_fin[ACC_W-1]}}, sum_fin},
      ACC_W, WIDTH_OUT);
    res_next = WIDTH_OUT'(s.val);
    sat_next = s.sat;
  end
`else
  assign res_next = sum_fin[WIDTH_OUT-1:0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MCA_IDLE: begin
        if (accept) state_d = MCA_ADDING;
      end
      MCA_ADDING: begin
        if (enable && last_beat) state_d = MCA_DONE;
      end
      MCA_DONE: begin
        if (enable && out_ready) state_d = MCA_IDLE;
      end
      default: state_d = MCA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MCA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_q <= '0;
      acc_q  <= '0;
      beat_q <= '0;
      res    <= '0;
`ifdef MCA_SATURATE_EN
      sat_flag <= 1'b0;
`endif
    end else if (enable) begin
      if (accept) begin
        snap_q <= operands;
        acc_q  <= '0;
        beat_q <= '0;
      end else if (state_q == MCA_ADDING) begin
        acc_q <= sum_fin;
        if (last_beat) begin
          beat_q <= '0;
          res    <= res_next;
`ifdef MCA_SATURATE_EN
          sat_flag <= sat_next;
`endif
        end else begin
          beat_q <= beat_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clk_adder_lanes.sv
// Directed bench for multi_clk_adder_lanes over three configurations.
// Checks latency, sums, wrap/saturate, back-pressure, enable, reset.
module tb_multi_clk_adder_lanes;

  logic clk;
  logic resetn;
  logic enable;
  logic out_ready;
  logic tog;

  logic iv  [3];
  logic rdy [3];
  logic ov  [3];
  logic bz  [3];

  logic [15:0][31:0] ops0;
  logic [9:0][31:0]  ops1;
  logic [3:0][7:0]   ops2;

  logic signed [31:0] r0;
  logic signed [31:0] r1;
  logic signed [7:0]  r2;
`ifdef MCA_SATURATE_EN
  logic sf0, sf1, sf2;
`endif

  int total;
  int bad;

  multi_clk_adder_lanes u0 (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (iv[0]),
    .in_ready  (rdy[0]),
    .operands  (ops0),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .res       (r0),
    .busy      (bz[0])
`ifdef MCA_SATURATE_EN
    ,
    .sat_flag  (sf0)
`endif
  );

  multi_clk_adder_lanes #(
    .NUM_OPERANDS (10),
    .LANES        (4)
  ) u1 (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (iv[1]),
    .in_ready  (rdy[1]),
    .operands  (ops1),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .res       (r1),
    .busy      (bz[1])
`ifdef MCA_SATURATE_EN
    ,
    .sat_flag  (sf1)
`endif
  );

  multi_clk_adder_lanes #(
    .WIDTH_IN     (8),
    .WIDTH_OUT    (8),
    .NUM_OPERANDS (4),
    .LANES        (2)
  ) u2 (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .in_valid  (iv[2]),
    .in_ready  (rdy[2]),
    .operands  (ops2),
    .out_valid (ov[2]),
    .out_ready (out_ready),
    .res       (r2),
    .busy      (bz[2])
`ifdef MCA_SATURATE_EN
    ,
    .sat_flag  (sf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable toggler changes away from both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tog) enable = ~enable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string              tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issues a job on lane sel; lat counts edges from the accept
  // edge (as 1) until out_valid is seen; -1 on timeout.
  task automatic job(
    input  int sel,
    output int lat,
    output int rdy_bad
  );
    bit acc;
    int n;
    acc = 0;
    n = 0;
    lat = -1;
    rdy_bad = 0;
    @(negedge clk);
    iv[sel] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (!acc && enable && rdy[sel]) acc = 1;
      @(posedge clk);
      if (acc) n++;
      @(negedge clk);
      if (acc) begin
        iv[sel] = 1'b0;
        if (rdy[sel]) rdy_bad++;
        if (ov[sel]) begin
          lat = n;
          break;
        end
      end
    end
    iv[sel] = 1'b0;
  endtask

  task automatic set_ops0_seq();
    for (int i = 0; i < 16; i++) ops0[i] = 32'(i + 1);
  endtask

  initial begin
    int lat;
    int rb;
    int stable_bad;
    int k;
    total = 0;
    bad = 0;
    tog = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    set_ops0_seq();
    for (int i = 0; i < 10; i++) ops1[i] = -32'sd3;
    for (int i = 0; i < 4; i++) ops2[i] = 8'd100;
    resetn = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", rdy[0], 1);
    check("rst_out_valid", ov[0], 0);
    check("rst_res", r0, 0);
    check("rst_busy", bz[0], 0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: defaults, sum 1..16
    job(0, lat, rb);
    check("t1_lat", lat, 17);
    check("t1_res", r0, 136);
    check("t1_rdy_low", rb, 0);
    check("t1_busy", bz[0], 1);
    @(negedge clk);
    check("t1_rdy_after", rdy[0], 1);
    check("t1_ov_after", ov[0], 0);
    check("t1_res_hold", r0, 136);

    // 2: 10 operands, 4 lanes, masked last beat
    job(1, lat, rb);
    check("t2_lat", lat, 4);
    check("t2_res", r1, -30);
    @(negedge clk);

    // 3: 8-bit wrap / saturate
    job(2, lat, rb);
    check("t3_lat", lat, 3);
`ifdef MCA_SATURATE_EN
    check("t3_pos_res", r2, 127);
    check("t3_pos_sat", sf2, 1);
`else
    check("t3_pos_res", r2, -112);
`endif
    for (int i = 0; i < 4; i++) ops2[i] = 8'h80;
    job(2, lat, rb);
`ifdef MCA_SATURATE_EN
    check("t3_neg_res", r2, -128);
    check("t3_neg_sat", sf2, 1);
`else
    check("t3_neg_res", r2, 0);
`endif
    ops2[0] = 8'd10;
    ops2[1] = 8'd20;
    ops2[2] = 8'hFB;
    ops2[3] = 8'd7;
    job(2, lat, rb);
    check("t3_mix_res", r2, 32);
`ifdef MCA_SATURATE_EN
    check("t3_mix_sat", sf2, 0);
`endif
    @(negedge clk);

    // 4: back-pressure, second job waits
    for (int i = 0; i < 16; i++) ops0[i] = 32'(2 * (i + 1));
    out_ready = 1'b0;
    job(0, lat, rb);
    check("t4_res1", r0, 272);
    for (int i = 0; i < 16; i++) ops0[i] = 32'd1;
    iv[0] = 1'b1;
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (r0 !== 32'sd272 || rdy[0] || !ov[0]) stable_bad++;
    end
    check("t4_stall", stable_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_rdy_hs", rdy[0], 1);
    check("t4_ov_hs", ov[0], 0);
    @(negedge clk);
    check("t4_accept2", bz[0], 1);
    iv[0] = 1'b0;
    for (k = 0; k < 100 && !ov[0]; k++) @(negedge clk);
    check("t4_ov2", ov[0], 1);
    check("t4_res2", r0, 16);
    @(negedge clk);

    // 5: enable toggling with operand change mid-job
    set_ops0_seq();
    tog = 1'b1;
    fork
      job(0, lat, rb);
      begin
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) ops0[i] = 32'd99;
      end
    join
    tog = 1'b0;
    enable = 1'b1;
    check("t5_lat", lat, 33);
    check("t5_res", r0, 136);
    @(negedge clk);
    check("t5_rdy_after", rdy[0], 1);

    // 6: async reset mid-job
    set_ops0_seq();
    @(negedge clk);
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_ov", ov[0], 0);
    check("t6_res", r0, 0);
    check("t6_rdy", rdy[0], 1);
    @(negedge clk);
    resetn = 1'b1;
    job(0, lat, rb);
    check("t6_lat", lat, 17);
    check("t6_res2", r0, 136);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_clk_adder_lanes.md
Name: multi_clk_adder_lanes

Overview:
- Parametrised multi-cycle summation unit for the FIR/digital-estimator datapath.
- Snapshots a vector of NUM_OPERANDS signed coefficients-products on a valid/ready handshake.
- Sums them LANES operands per cycle in a full-precision accumulator.
- Presents the result on a valid/ready output port.
- Generalises the fixed 16-operand, one-operand-per-cycle adder: arbitrary operand count, lane count and output width, and back-pressure.

Parameters:
- WIDTH_IN, 32: operand width, signed.
- WIDTH_OUT, 32: result width, signed; must be 1..ACC_W.
- NUM_OPERANDS, 16: operands per job; must be >=1.
- LANES, 1: operands added per active cycle; must be 1..NUM_OPERANDS.
- Derived, not overridable:
  - NUM_BEATS = ceil(NUM_OPERANDS/LANES).
  - ACC_W = WIDTH_IN + $clog2(NUM_OPERANDS) + 1.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous, active-low reset
- enable  input  1  global clock-enable; when 0 all state, counters and registers hold
- in_valid  input  1  operand vector valid
- in_ready  output  1  block can accept a job
- operands  input  WIDTH_IN x NUM_OPERANDS  signed operand array, sampled only on accept
- out_valid  output  1  res valid
- out_ready  input  1  consumer accepts res
- res  output  WIDTH_OUT  signed sum
- busy  output  1  state != MCA_IDLE

Behaviour:
- Reset values: state MCA_IDLE; beat counter 0; accumulator 0; res 0; out_valid 0; in_ready 1; busy 0.
- Reset mid-job aborts the job silently; no partial result is emitted.
- Accept occurs when enable && in_valid && in_ready. On accept, operands are copied into an internal snapshot register, acc is cleared and state goes to MCA_ADDING.
- in_ready = (state == MCA_IDLE), combinational from state only.
- MCA_ADDING: each enabled cycle, acc += sign-extended sum of snapshot[beat*LANES +: LANES].
  - On the last beat, lanes with index >= NUM_OPERANDS contribute 0.
  - beat increments each enabled cycle.
  - When beat == NUM_BEATS-1: beat clears, state goes to MCA_DONE and res is loaded with the final sum truncated to WIDTH_OUT (two's-complement wrap).
- MCA_DONE: out_valid = 1 and res holds stable.
  - On enable && out_ready, state goes to MCA_IDLE.
  - res keeps its value after the handshake; out_valid drops.
- Latency:
  - Accept edge to out_valid high = NUM_BEATS+1 enabled cycles (1 snapshot cycle + NUM_BEATS adding cycles).
  - Sustained throughput = 1 job per NUM_BEATS+2 cycles with out_ready tied high.
- Internal arithmetic is always full-width ACC_W, so no intermediate overflow is possible.
- Operand changes after accept have no effect on the job.
- in_valid while busy is ignored; the producer must hold it until in_ready.
- enable = 0 freezes everything, including the output handshake; out_valid stays asserted.
- NUM_OPERANDS = 1 or LANES = NUM_OPERANDS gives NUM_BEATS = 1, i.e. a single adding cycle.

Optional Feature:
- Macro: MCA_SATURATE_EN.
- Defined:
  - Final ACC_W sum is clamped to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] before loading res.
  - Extra output port sat_flag (1 bit) is added; it is set with res when clamping occurred and reset to 0.
- Undefined: res takes the low WIDTH_OUT bits (wrap) and the sat_flag port does not exist.

Decomposition:
- FIR_pkg gains:
  - enum state_mcal_e {MCA_IDLE, MCA_ADDING, MCA_DONE} (2-bit);
  - a function computing NUM_BEATS (ceil divide);
  - a saturate function (width-parametrised through ACC_W/WIDTH_OUT arguments).
- One sub-module, mca_lane_sum: purely combinational.
  - Inputs: LANES signed WIDTH_IN values plus a per-lane mask.
  - Output: a signed ACC_W sum.
  - Instantiated once; it keeps the adder tree separate from the FSM.

Test Plan:
1. Defaults, operands[i] = i+1 (i = 0..15), out_ready = 1 -> out_valid 17 cycles after accept, res = 136; in_ready low throughout and high the cycle after the output handshake.
2. NUM_OPERANDS = 10, LANES = 4, all operands = -3 -> NUM_BEATS = 3, masked last beat, res = -30, out_valid 4 cycles after accept.
3. WIDTH_IN = WIDTH_OUT = 8, NUM_OPERANDS = 4, operands all 100 -> without the macro res = 400 mod 256 = -112 as signed; with MCA_SATURATE_EN res = 127 and sat_flag = 1. All operands -128 with MCA_SATURATE_EN -> res = -128, sat_flag = 1 (sum -512 clamps to the negative limit).
4. out_ready held low 5 cycles after completion, in_valid high with new data -> res stable, in_ready 0, no second accept. Then out_ready = 1 -> the second job is accepted next cycle.
5. enable toggled 0/1 every other cycle during scenario 1 -> same res = 136, latency doubles in clock cycles; operands changed mid-job -> res unchanged.
6. resetn pulsed low at beat 7 -> out_valid 0, res 0, in_ready 1 immediately (asynchronous); a subsequent job returns a correct sum.
